// File: rtl/wb_pkg.sv
// Writeback-source encodings shared by the writeback stage and its users.
package wb_pkg;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_ALU  = 2'd0;
  localparam wb_sel_t WB_SEL_MEM  = 2'd1;
  localparam wb_sel_t WB_SEL_LINK = 2'd2;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, r0 hardwired to zero, combinational reads, no bypass.
// Write lands on the rising edge; no backpressure.
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: latches the MEM/WB result (1 edge), commits it to the regfile (2nd edge),
// bypasses the latched result to both read ports; never stalls, flush kills both entries.
module wb_regfile_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  wb_sel_t           in_wb_sel,
  input  logic [AW-1:0]     in_dest,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_link_addr,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [AW-1:0]     wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              wb_rw;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              commit;

  // Reserved select falls back to the ALU result.
  always_comb begin
    sel_data = in_alu_result;
    case (in_wb_sel)
      WB_SEL_MEM:  sel_data = in_mem_data;
      WB_SEL_LINK: sel_data = in_link_addr;
      default:     sel_data = in_alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rw    <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= in_valid & ~flush;
      wb_rw    <= in_reg_write;
      wb_dest  <= in_dest;
      wb_data  <= sel_data;
    end
  end

  assign wb_we  = wb_valid & wb_rw & (wb_dest != '0);
  assign commit = wb_valid & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_count <= '0;
    else if (commit) retire_count <= retire_count + CNT_W'(1);
  end

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit & wb_we),
    .waddr  (wb_dest),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // wb_we already excludes r0, so the bypass can never leak a write to register 0.
  assign rs1_data = (wb_we && rs1_addr == wb_dest) ? wb_data : rf_rd1;
  assign rs2_data = (wb_we && rs2_addr == wb_dest) ? wb_data : rf_rd2;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: reference model plus directed scenarios with literal expectations.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_reg_write = 1'b0;
  logic [1:0]  in_wb_sel = 2'd0;
  logic [4:0]  in_dest = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic [31:0] in_mem_data = 32'd0;
  logic [31:0] in_link_addr = 32'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_dest;
  logic [3:0]  retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  wb_regfile_stage #(.DATA_W(32), .NUM_REGS(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_dest(in_dest),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_link_addr(in_link_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers, the one in-flight result, and a mod-16 count.
  logic [31:0] m_rf [32];
  logic        m_v, m_rw;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [3:0]  m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
      m_v <= 1'b0; m_rw <= 1'b0; m_dest <= 5'd0; m_data <= 32'd0; m_cnt <= 4'd0;
    end else begin
      if (m_v && !flush) begin
        if (m_rw && m_dest != 5'd0) m_rf[m_dest] <= m_data;
        m_cnt <= m_cnt + 4'd1;
      end
      m_v    <= in_valid && !flush;
      m_rw   <= in_reg_write;
      m_dest <= in_dest;
      m_data <= (in_wb_sel == 2'd1) ? in_mem_data :
                (in_wb_sel == 2'd2) ? in_link_addr : in_alu_result;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_v && m_rw && m_dest == a) return m_data;
    return m_rf[a];
  endfunction

  always @(posedge clk) begin
    #2;
    chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, m_v});
    chk("m_wb_we", {31'd0, wb_we}, {31'd0, m_v && m_rw && m_dest != 5'd0});
    chk("m_wb_dest", {27'd0, wb_dest}, {27'd0, m_dest});
    chk("m_wb_data", wb_data, m_data);
    chk("m_retire", {28'd0, retire_count}, {28'd0, m_cnt});
    chk("m_rs1", rs1_data, exp_rd(rs1_addr));
    chk("m_rs2", rs2_data, exp_rd(rs2_addr));
  end

  task automatic send(input logic rw, input logic [1:0] sel, input logic [4:0] dest,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link);
    @(negedge clk);
    in_valid = 1'b1; in_reg_write = rw; in_wb_sel = sel; in_dest = dest;
    in_alu_result = alu; in_mem_data = mem; in_link_addr = link;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_reg_write = 1'b0;
  endtask

  initial begin
    // 1: reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rs1_addr = 5'd5;
    #1;
    chk("reset_rs1", rs1_data, 32'd0);
    chk("reset_count", {28'd0, retire_count}, 32'd0);
    chk("reset_valid", {31'd0, wb_valid}, 32'd0);

    // 2: ALU write, bypass then architectural
    send(1'b1, 2'd0, 5'd3, 32'hDEADBEEF, 32'h0, 32'h0);
    rs1_addr = 5'd3;
    idle();
    chk("alu_wb_data", wb_data, 32'hDEADBEEF);
    chk("alu_bypass", rs1_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_rf", rs1_data, 32'hDEADBEEF);
    chk("alu_count", {28'd0, retire_count}, 32'd1);

    // 3: source select, back-to-back
    send(1'b1, 2'd1, 5'd4, 32'hAAAA, 32'h1234, 32'h0);
    send(1'b1, 2'd2, 5'd31, 32'hBBBB, 32'h0, 32'h400);
    send(1'b1, 2'd3, 5'd5, 32'h55, 32'h66, 32'h77);
    idle();
    @(negedge clk);
    rs1_addr = 5'd4; rs2_addr = 5'd31; #1;
    chk("sel_mem", rs1_data, 32'h1234);
    chk("sel_link", rs2_data, 32'h400);
    rs1_addr = 5'd5; #1;
    chk("sel_rsvd", rs1_data, 32'h55);
    chk("sel_count", {28'd0, retire_count}, 32'd4);

    // 4: r0 write dropped but retired
    send(1'b1, 2'd0, 5'd0, 32'hFFFF, 32'h0, 32'h0);
    rs1_addr = 5'd0;
    idle();
    chk("r0_we", {31'd0, wb_we}, 32'd0);
    chk("r0_valid", {31'd0, wb_valid}, 32'd1);
    chk("r0_read", rs1_data, 32'd0);
    @(negedge clk);
    chk("r0_count", {28'd0, retire_count}, 32'd5);

    // 5: flush kills latched dest 7 and incoming dest 8
    send(1'b1, 2'd0, 5'd7, 32'd9, 32'h0, 32'h0);
    send(1'b1, 2'd0, 5'd8, 32'd10, 32'h0, 32'h0);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    rs1_addr = 5'd7; rs2_addr = 5'd8; #1;
    chk("flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_count", {28'd0, retire_count}, 32'd5);
    chk("flush_r7", rs1_data, 32'd0);
    chk("flush_r8", rs2_data, 32'd0);

    // back-to-back same dest, dual bypass
    send(1'b1, 2'd0, 5'd6, 32'd1, 32'h0, 32'h0);
    send(1'b1, 2'd0, 5'd6, 32'd2, 32'h0, 32'h0);
    rs1_addr = 5'd6; rs2_addr = 5'd6;
    idle();
    chk("b2b_bypass1", rs1_data, 32'd2);
    chk("b2b_bypass2", rs2_data, 32'd2);
    @(negedge clk);
    chk("b2b_rf", rs1_data, 32'd2);
    chk("b2b_count", {28'd0, retire_count}, 32'd7);

    // 6: async reset between edges discards latched entry
    send(1'b1, 2'd0, 5'd9, 32'h77, 32'h0, 32'h0);
    rs1_addr = 5'd9; rs2_addr = 5'd3;
    @(posedge clk);
    #3;
    in_valid = 1'b0; in_reg_write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_we", {31'd0, wb_we}, 32'd0);
    chk("arst_dest", {27'd0, wb_dest}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_count", {28'd0, retire_count}, 32'd0);
    chk("arst_rs1", rs1_data, 32'd0);
    chk("arst_rs2", rs2_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_r9", rs1_data, 32'd0);

    // wrap: 17 retires on a 4-bit counter
    for (int i = 0; i < 17; i++)
      send(i[0], 2'd0, 5'(i + 10), 32'(i * 3), 32'h0, 32'h0);
    idle();
    @(negedge clk);
    chk("wrap_count", {28'd0, retire_count}, 32'd1);
    rs1_addr = 5'd12; #1;
    chk("wrap_r12", rs1_data, 32'd0);
    rs1_addr = 5'd11; #1;
    chk("wrap_r11", rs1_data, 32'd3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
